// File: rtl/led_pkg.sv
// Shared definitions for the LED channel pipeline: level width, fade state and
// the perceptual gamma curve used by the PWM shaping stage.
package led_pkg;

  localparam int unsigned LEVEL_W = 8;

  typedef enum logic [1:0] {
    SETTLED   = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } fade_state_t;

  // ((lvl+1)^2 - 1) >> 8 in 16 bits; 256*256 wraps to 0 so 255 still maps to 0xFFFF.
  function automatic logic [LEVEL_W-1:0] gamma(input logic [LEVEL_W-1:0] lvl);
    logic [15:0] p;
    p = 16'(lvl) + 16'd1;
    p = (p * p) - 16'd1;
    return p[15:8];
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: o_tick pulses for one cycle every PRESCALE non-hold cycles;
// i_hold freezes the count without losing progress through the period.
module led_tick_gen #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hold,
  output logic o_tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == LAST);
  assign o_tick = w_last & ~i_hold;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (!i_hold) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/led_fader.sv
// Per-channel slew-rate limiter: ramps level toward the registered target by at
// most STEP per prescaled tick. Define LED_FADER_GAMMA_EN for quadratic duty shaping.
module led_fader
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned STEP     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LEVEL_W-1:0] target,
  input  logic               hold,
  output logic [LEVEL_W-1:0] duty,
  output logic [LEVEL_W-1:0] level,
  output logic               ramping,
  output logic               settled
);

  localparam logic [LEVEL_W:0] STEP_LIM = 9'(STEP);

  logic [LEVEL_W-1:0] r_tq;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] r_duty;
  fade_state_t        r_state;

  logic               w_tick;
  fade_state_t        w_state;
  logic [LEVEL_W:0]   w_up_diff;
  logic [LEVEL_W:0]   w_dn_diff;
  logic [LEVEL_W-1:0] w_up_amt;
  logic [LEVEL_W-1:0] w_dn_amt;
  logic [LEVEL_W-1:0] w_level_nxt;
  logic [LEVEL_W-1:0] w_shaped;

  led_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .i_clk (clk),
    .i_rst (reset),
    .i_hold(hold),
    .o_tick(w_tick)
  );

  assign w_up_diff = {1'b0, r_tq} - {1'b0, r_level};
  assign w_dn_diff = {1'b0, r_level} - {1'b0, r_tq};
  assign w_up_amt  = (w_up_diff < STEP_LIM) ? w_up_diff[LEVEL_W-1:0] : STEP_LIM[LEVEL_W-1:0];
  assign w_dn_amt  = (w_dn_diff < STEP_LIM) ? w_dn_diff[LEVEL_W-1:0] : STEP_LIM[LEVEL_W-1:0];

  // Step direction comes from the live compare so a target change can never overshoot.
  always_comb begin
    w_state     = SETTLED;
    w_level_nxt = r_level;
    if (r_level < r_tq) begin
      w_state     = RAMP_UP;
      w_level_nxt = r_level + w_up_amt;
    end else if (r_level > r_tq) begin
      w_state     = RAMP_DOWN;
      w_level_nxt = r_level - w_dn_amt;
    end
  end

`ifdef LED_FADER_GAMMA_EN
  assign w_shaped = gamma(r_level);
`else
  assign w_shaped = r_level;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tq    <= '0;
      r_level <= '0;
      r_duty  <= '0;
      r_state <= SETTLED;
    end else begin
      r_tq    <= target;
      r_state <= w_state;
      r_duty  <= w_shaped;
      if (w_tick) begin
        r_level <= w_level_nxt;
      end
    end
  end

  assign level   = r_level;
  assign duty    = r_duty;
  assign settled = (r_state == SETTLED);
  assign ramping = (r_state != SETTLED);

endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Per-channel slew-rate limiter between the rotary-encoder level counter and the PWM generator.
- Takes the 8-bit target level from the encoder and ramps an internal level toward it at a fixed step per prescaled tick. The result is smooth fades instead of jumps.
- Drives the PWM duty input and reports ramp status. One instance per R/G/B channel.

Parameters:
- PRESCALE, 1000: clk cycles per ramp tick; must be >= 1.
- STEP, 1: maximum level change per tick, 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- target  input  8  requested level from encoder stage
- hold  input  1  freeze: prescaler and level do not advance while high
- duty  output  8  registered duty value to PWM stage
- level  output  8  current ramped level (pre-shaping)
- ramping  output  1  high while state is RAMP_UP or RAMP_DOWN
- settled  output  1  high when level == registered target

Behaviour:
- Reset (async, active-high): target_q=0, level=0, duty=0, prescaler count=0, state=SETTLED, settled=1, ramping=0.
- target is registered into target_q every cycle. All decisions use target_q, giving 1 cycle of input latency.
- Prescaler:
  - count runs 0..PRESCALE-1 and wraps to 0.
  - tick is asserted for the single cycle where count==PRESCALE-1 and hold==0.
  - PRESCALE=1 gives tick every non-hold cycle.
  - hold=1 freezes count; no tick is generated.
- State register, recomputed every cycle from level vs target_q (registered):
  - SETTLED when level==target_q.
  - RAMP_UP when level<target_q.
  - RAMP_DOWN when level>target_q.
- Level update on tick:
  - RAMP_UP: level += min(STEP, target_q-level).
  - RAMP_DOWN: level -= min(STEP, level-target_q).
  - SETTLED: no change.
  - Never overshoots; never wraps below 0 or above 255. Difference arithmetic uses 9-bit unsigned.
- Target change mid-ramp: the new direction applies from the next tick. No extra delay and no restart of the prescaler.
- ramping and settled are registered outputs derived from the state register; they are mutually exclusive.
- duty is registered 1 cycle after level (shaping stage, see Optional Feature).
- hold asserted mid-ramp: level holds its value. The ramp resumes with the prescaler count preserved when hold drops.
- Reset mid-ramp: everything returns to reset values immediately; no partial step.

Optional Feature:
- Macro LED_FADER_GAMMA_EN.
- Defined: duty = (((level+1)*(level+1)) - 1) >> 8, computed 16-bit and registered. This is a perceptual quadratic curve. Examples: 0->0, 1->0, 15->0, 16->1, 128->65, 255->255.
- Undefined: duty = level, registered. Latency is 1 cycle in both cases.

Decomposition:
- Shared package led_pkg holds:
  - LEVEL_W=8.
  - A fade_state_t enum {SETTLED, RAMP_UP, RAMP_DOWN}, 2 bits.
  - The gamma function, so the mixer and any future channel reuse it.
- One sub-module, led_tick_gen: parameterised prescaler with hold and a tick output. It is reusable by the encoder debounce sampling.

Test Plan (PRESCALE=4, STEP=1 unless stated):
- Reset, then target=10 held -> level increments by 1 every 4 cycles and reaches 10 after 10 ticks; ramping=1 throughout, then settled=1 and ramping=0; no overshoot.
- STEP=7, level=250, target=255 -> next tick level=255 (clamped, no wrap). Then target=3 -> levels go 248, 241, …, 10, then 3 exactly, then settled.
- Ramp to 200, switch target to 50 at level 100 -> direction flips at the next tick; level goes 99, 98, … down to 50.
- hold=1 for 20 cycles mid-ramp at level 40 -> level stays 40 and the prescaler count is frozen. On release, the first tick arrives after the remaining count cycles, not a full period.
- Assert reset asynchronously mid-ramp (level 77) -> level, duty and target_q are 0 in the same cycle; settled=1.
- LED_FADER_GAMMA_EN defined: force levels 0, 16, 128, 255 -> duty 0, 1, 65, 255 one cycle later. Undefined: duty equals level one cycle later.
